ysyx_22050019_sram_rsp: RTL and testbench
=========================================

# ysyx_22050019_sram_rsp

Memory-side responder for the core's data-memory port. Accepts one load/store request at a time over a valid/ready request channel and holds it in a latch. It performs the access on an internal 64-bit-word SRAM array. It returns read data, or a write acknowledgement, over a valid/ready response channel after a programmable latency. It sits between the core's load/store path and the memory map, and replaces the zero-latency combinational memory model so that the core can be tested against realistic wait states.

## Interface
- `DEPTH`, 1024: number of 64-bit words in the array; power of two.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 2: cycles from request acceptance to `rsp_valid`; legal range ≥ 1.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address; bits [2:0] are ignored for word selection.
- `req_wdata` in 64: store data, aligned to the 64-bit word lanes.
- `req_wmask` in 8: per-byte store enables; ignored for loads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: initiator accepts the response.
- `rsp_rdata` out 64: load data; 0 for stores and for errors.
- `rsp_err` out 1: the address was outside [BASE, BASE+DEPTH*8).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch `req_we`, the word index and the in-range flag.
    - Store and in range: write the masked bytes to the array on the acceptance edge.
    - Next state is WAIT if LATENCY>1, otherwise RESP.
    - Counter loads LATENCY-2 when entering WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
    - Load data is captured into `rsp_rdata` on the edge that enters RESP. It is the array word at the latched index, or 0 if out of range or a store.
    - The same capture rule applies on the IDLE→RESP path.
  - RESP: `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable. On `rsp_ready`=1, go to IDLE.
- Only one transaction is outstanding. `req_ready`=0 in WAIT and RESP.
- Range check: `in_range` = (`req_addr` ≥ BASE) && (`req_addr`-BASE < DEPTH*8).
  - Word index = (`req_addr`-BASE)[$clog2(DEPTH)+2:3].
  - Out-of-range stores do not modify the array.
- Loads ignore `req_wmask` and always return the full 64-bit word. The core performs width extraction and sign extension.
- Byte lane i of the word is written iff `req_wmask`[i]; other lanes keep their value.
- A load that follows a store to the same word sees the stored data.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
- Array contents are not affected by reset.
- With acceptance in cycle T, `rsp_valid` rises in cycle T+LATENCY.
- Response handshake in cycle R: `rsp_valid`=0 and `req_ready`=1 in R+1. The earliest next acceptance is R+1, so minimum throughput is one transaction per LATENCY+1 cycles.
- `rsp_ready` held high before `rsp_valid` is legal and completes the response in its first valid cycle.
- `req_valid` while busy is ignored. The initiator must hold the request stable until `req_ready`.
- Reset asserted mid-transaction: the transaction is dropped and no response is produced. A store already committed on its acceptance edge stays committed.
- Counter width is $clog2(LATENCY) bits, minimum 1.

## Structure
- Shared package `ysyx_22050019_pkg`: FSM state enum (IDLE/WAIT/RESP) and bus width constants (ADDR_W=64, DATA_W=64, MASK_W=8).
- One sub-module, `ysyx_22050019_sram_array`:
  - `DEPTH`×64 storage.
  - Synchronous byte-masked write port.
  - Asynchronous read port indexed by the latched word index.
- FSM, counter, range check and response registers live in the top module.

## Test plan
- Reset, then store 64'h1122_3344_5566_7788 to 0x8000_0010 with mask 8'hFF → `rsp_valid` exactly 2 cycles after acceptance, `rsp_rdata`=0, `rsp_err`=0. A load from 0x8000_0010 then returns 64'h1122_3344_5566_7788.
- Store 64'hAAAA_AAAA_AAAA_AAAA to 0x8000_0010 with mask 8'h0F → a load returns 64'h1122_3344_AAAA_AAAA.
- Hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0 throughout, and `req_valid` pulses are ignored. Releasing `rsp_ready` gives `req_ready`=1 the next cycle.
- Load from 0x7FFF_FFF8 and from BASE+DEPTH*8 → `rsp_err`=1, `rsp_rdata`=0. A store to BASE+DEPTH*8 leaves word 0 and word DEPTH-1 unchanged.
- Instantiate with LATENCY=1 and LATENCY=5 → `rsp_valid` appears at T+1 and T+5 respectively. Back-to-back transactions are accepted every LATENCY+1 cycles with `rsp_ready` tied high.
- Assert `rst` during WAIT of a load → `rsp_valid` stays 0, `req_ready`=1 after reset, and the next load completes normally.

Source files
------------

// File: rtl/ysyx_22050019_pkg.sv
// Shared types and bus widths for the data-memory responder.
package ysyx_22050019_pkg;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic we;
        logic in_range;
    } req_meta_t;
endpackage

// File: rtl/ysyx_22050019_sram_array.sv
// 64-bit word storage split into byte lanes; synchronous masked write, asynchronous read.
module ysyx_22050019_sram_array
    import ysyx_22050019_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    for (genvar i = 0; i < MASK_W; i++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we && wmask[i]) mem[waddr] <= wdata[i*8 +: 8];
        end

        assign rdata[i*8 +: 8] = mem[raddr];
    end
endmodule

// File: rtl/ysyx_22050019_sram_rsp.sv
// Single-outstanding load/store responder with programmable response latency.
module ysyx_22050019_sram_rsp
    import ysyx_22050019_pkg::*;
#(
    parameter int              DEPTH   = 1024,
    parameter logic [63:0]     BASE    = 64'h8000_0000,
    parameter int              LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH) * 64'd8;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    req_meta_t           meta_q, meta_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   off;
    logic                in_range;
    logic [IDX_W-1:0]    req_idx;
    logic                accept;
    req_meta_t           cur_meta;
    logic [IDX_W-1:0]    cur_idx;
    logic [DATA_W-1:0]   arr_rdata;

    assign off      = req_addr - BASE;
    assign in_range = (req_addr >= BASE) && (off < SPAN);
    assign req_idx  = off[IDX_W+2:3];
    assign accept   = (state_q == IDLE) && req_valid;

    // The IDLE->RESP path (LATENCY=1) captures before the latch is loaded, so bypass it.
    assign cur_meta = (state_q == IDLE) ? '{we: req_we, in_range: in_range} : meta_q;
    assign cur_idx  = (state_q == IDLE) ? req_idx : idx_q;

    ysyx_22050019_sram_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
        .clk   (clk),
        .we    (accept && req_we && in_range),
        .waddr (req_idx),
        .wdata (req_wdata),
        .wmask (req_wmask),
        .raddr (cur_idx),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meta_d  = meta_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    meta_d = '{we: req_we, in_range: in_range};
                    idx_d  = req_idx;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                        rdata_d = (cur_meta.we || !cur_meta.in_range) ? '0 : arr_rdata;
                        err_d   = !cur_meta.in_range;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = (cur_meta.we || !cur_meta.in_range) ? '0 : arr_rdata;
                    err_d   = !cur_meta.in_range;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            meta_q  <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meta_q  <= meta_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_ysyx_22050019_sram_rsp.sv
// Directed bench: one responder per latency (2, 1, 5) sharing clock and reset.
module tb_ysyx_22050019_sram_rsp;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [63:0] req_addr  [3];
    logic [63:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [63:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050019_sram_rsp #(.DEPTH(1024), .BASE(BASE), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_22050019_sram_rsp #(.DEPTH(16), .BASE(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    ysyx_22050019_sram_rsp #(.DEPTH(16), .BASE(BASE), .LATENCY(5)) u_l5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request and return just after its acceptance edge.
    task automatic issue(input int d, input string tag, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask);
        @(posedge clk); #1;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_wmask[d] = mask;
        @(negedge clk);
        chk({tag, "/req_ready"}, 64'(req_ready[d]), 64'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    // Count cycles from acceptance to the first rsp_valid, then check payload.
    task automatic await_rsp(input int d, input string tag, input int lat,
                             input logic [63:0] rdata, input logic err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[d] && n < 20);
        chk({tag, "/latency"}, 64'(n), 64'(lat));
        chk({tag, "/rdata"}, rsp_rdata[d], rdata);
        chk({tag, "/err"}, 64'(rsp_err[d]), 64'(err));
    endtask

    task automatic finish_rsp(input int d, input string tag);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        chk({tag, "/valid_drop"}, 64'(rsp_valid[d]), 64'd0);
        chk({tag, "/ready_back"}, 64'(req_ready[d]), 64'd1);
    endtask

    task automatic txn(input int d, input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask, input int lat,
                       input logic [63:0] rdata, input logic err);
        issue(d, tag, we, addr, wdata, mask);
        await_rsp(d, tag, lat, rdata, err);
        finish_rsp(d, tag);
    endtask

    // Loads with req_valid and rsp_ready held high; acceptances must be LATENCY+1 apart.
    task automatic b2b(input int d, input string tag, input int lat, input logic [63:0] exp);
        int acc [$];
        int gap0, gap1;
        @(posedge clk); #1;
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = BASE + 64'd8;
        req_wmask[d] = 8'h00; rsp_ready[d] = 1'b1;
        for (int c = 0; c < 3 * (lat + 1); c++) begin
            @(negedge clk);
            if (req_ready[d]) acc.push_back(c);
            if (rsp_valid[d]) chk({tag, "/rdata"}, rsp_rdata[d], exp);
        end
        req_valid[d] = 1'b0;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        gap0 = (acc.size() >= 2) ? acc[1] - acc[0] : 0;
        gap1 = (acc.size() >= 3) ? acc[2] - acc[1] : 0;
        chk({tag, "/accepts"}, 64'(acc.size()), 64'd3);
        chk({tag, "/gap0"}, 64'(gap0), 64'(lat + 1));
        chk({tag, "/gap1"}, 64'(gap1), 64'(lat + 1));
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wmask[d] = '0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst/req_ready", 64'(req_ready[0]), 64'd1);
        chk("rst/rsp_valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst/rsp_rdata", rsp_rdata[0], 64'd0);
        chk("rst/rsp_err", 64'(rsp_err[0]), 64'd0);

        txn(0, "st_full", 1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2, 64'd0, 1'b0);
        txn(0, "ld_full", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122_3344_5566_7788, 1'b0);
        txn(0, "st_mask", 1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 2, 64'd0, 1'b0);
        txn(0, "ld_mask", 1'b0, 64'h8000_0017, 64'd0, 8'h00, 2, 64'h1122_3344_AAAA_AAAA, 1'b0);

        // Backpressure: response held, busy-time requests (a clobbering store) ignored.
        issue(0, "hold", 1'b0, 64'h8000_0010, 64'd0, 8'h00);
        await_rsp(0, "hold", 2, 64'h1122_3344_AAAA_AAAA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req_valid[0] = (i % 2 == 0); req_we[0] = 1'b1;
            req_addr[0] = 64'h8000_0010; req_wdata[0] = 64'hDEAD_BEEF_DEAD_BEEF; req_wmask[0] = 8'hFF;
            @(negedge clk);
            chk("hold/valid", 64'(rsp_valid[0]), 64'd1);
            chk("hold/rdata", rsp_rdata[0], 64'h1122_3344_AAAA_AAAA);
            chk("hold/req_ready", 64'(req_ready[0]), 64'd0);
        end
        req_valid[0] = 1'b0;
        finish_rsp(0, "hold");
        txn(0, "hold_after", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122_3344_AAAA_AAAA, 1'b0);

        // Range boundaries.
        txn(0, "st_w0", 1'b1, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2, 64'd0, 1'b0);
        txn(0, "st_wlast", 1'b1, 64'h8000_1FF8, 64'hFEDC_BA98_7654_3210, 8'hFF, 2, 64'd0, 1'b0);
        txn(0, "ld_below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 2, 64'd0, 1'b1);
        txn(0, "ld_above", 1'b0, 64'h8000_2000, 64'd0, 8'h00, 2, 64'd0, 1'b1);
        txn(0, "st_above", 1'b1, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 64'd0, 1'b1);
        txn(0, "ld_w0", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 2, 64'h0123_4567_89AB_CDEF, 1'b0);
        txn(0, "ld_wlast", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 2, 64'hFEDC_BA98_7654_3210, 1'b0);

        // Reset during WAIT drops the load; array contents survive.
        issue(0, "rst_mid", 1'b0, 64'h8000_0000, 64'd0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid/valid", 64'(rsp_valid[0]), 64'd0);
        chk("rst_mid/req_ready", 64'(req_ready[0]), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid/no_rsp", 64'(rsp_valid[0]), 64'd0);
        end
        txn(0, "rst_after", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 2, 64'h1122_3344_AAAA_AAAA, 1'b0);

        // LATENCY=1 and LATENCY=5 instances.
        txn(1, "l1_st", 1'b1, 64'h8000_0008, 64'h5555_6666_7777_8888, 8'hFF, 1, 64'd0, 1'b0);
        txn(1, "l1_ld", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 1, 64'h5555_6666_7777_8888, 1'b0);
        b2b(1, "l1_b2b", 1, 64'h5555_6666_7777_8888);
        txn(2, "l5_st", 1'b1, 64'h8000_0008, 64'h0F0F_1E1E_2D2D_3C3C, 8'hFF, 5, 64'd0, 1'b0);
        txn(2, "l5_ld", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 5, 64'h0F0F_1E1E_2D2D_3C3C, 1'b0);
        b2b(2, "l5_b2b", 5, 64'h0F0F_1E1E_2D2D_3C3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
